// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code decoder that turns fresh presses of eleven keys into commands,
// queues them in a small FIFO and lights a held quadrant LED for each popped quadrant.
module ps2_key_sequencer #(
   parameter int HOLD_CYCLES = 10000000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] code_in,
   input  logic       code_valid,
   input  logic       code_err,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [3:0] cmd_code,
   output logic [8:0] quadrant_led,
   output logic       overflow,
   output logic       busy
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   function automatic logic [3:0] map_key(input logic [7:0] code);
      case (code)
         8'h16:   map_key = 4'd1;
         8'h1E:   map_key = 4'd2;
         8'h26:   map_key = 4'd3;
         8'h25:   map_key = 4'd4;
         8'h2E:   map_key = 4'd5;
         8'h36:   map_key = 4'd6;
         8'h3D:   map_key = 4'd7;
         8'h3E:   map_key = 4'd8;
         8'h46:   map_key = 4'd9;
         8'h15:   map_key = 4'd10;
         8'h1D:   map_key = 4'd11;
         default: map_key = 4'd0;
      endcase
   endfunction

   function automatic logic [10:0] key_mask(input logic [3:0] key);
      if (key == 4'd0) begin
         key_mask = 11'd0;
      end else begin
         key_mask = 11'd1 << (key - 4'd1);
      end
   endfunction

   function automatic logic [8:0] quad_onehot(input logic [3:0] quad);
      quad_onehot = 9'd1 << (quad - 4'd1);
   endfunction

   state_t             state_r;
   logic [10:0]        held_r;
   logic [3:0]         mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               cmd_valid_r;
   logic [3:0]         cmd_code_r;
   logic [8:0]         led_r;
   logic [HOLD_W-1:0]  hold_r;
   logic               overflow_r;
   logic               busy_r;

   logic [3:0]         key_s;
   logic [10:0]        mask_s;
   logic               is_e0_s;
   logic               is_f0_s;
   logic               good_s;
   logic               make_s;
   logic               break_s;
   logic               push_s;
   logic               pop_s;
   logic               accept_s;
   logic               drop_s;
   logic               quad_pop_s;
   state_t             state_nx_s;
   logic [CNT_W-1:0]   count_nx_s;
   logic [CNT_W-1:0]   after_pop_s;
   logic [PTR_W-1:0]   rd_ptr_nx_s;
   logic [3:0]         head_nx_s;

   // Byte decode, FIFO handshake and the next-state values the registers load.
   always_comb begin
      key_s       = map_key(code_in);
      mask_s      = key_mask(key_s);
      is_e0_s     = (code_in == 8'hE0);
      is_f0_s     = (code_in == 8'hF0);
      good_s      = code_valid && !code_err;
      make_s      = good_s && (state_r == ST_IDLE) && !is_e0_s && !is_f0_s && (key_s != 4'd0);
      break_s     = good_s && (state_r == ST_BRK) && (key_s != 4'd0);
      push_s      = make_s && ((held_r & mask_s) == 11'd0);
      pop_s       = cmd_valid_r && cmd_ready;
      accept_s    = push_s && ((count_r != FULL_CNT) || pop_s);
      drop_s      = push_s && (count_r == FULL_CNT) && !pop_s;
      quad_pop_s  = pop_s && (cmd_code_r >= 4'd1) && (cmd_code_r <= 4'd9);
      after_pop_s = count_r - CNT_W'(pop_s);
      count_nx_s  = after_pop_s + CNT_W'(accept_s);
      if (pop_s) begin
         rd_ptr_nx_s = rd_ptr_r + PTR_W'(1);
      end else begin
         rd_ptr_nx_s = rd_ptr_r;
      end
      // A push into a queue that is empty after this cycle's pop becomes the new head.
      if (accept_s && (after_pop_s == '0)) begin
         head_nx_s = key_s;
      end else begin
         head_nx_s = mem_r[rd_ptr_nx_s];
      end
      state_nx_s = state_r;
      if (!code_valid) begin
         state_nx_s = state_r;
      end else if (code_err) begin
         state_nx_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (is_e0_s) begin
                  state_nx_s = ST_EXT;
               end else if (is_f0_s) begin
                  state_nx_s = ST_BRK;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_EXT: begin
               if (is_f0_s) begin
                  state_nx_s = ST_EXT_BRK;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_BRK:     state_nx_s = ST_IDLE;
            ST_EXT_BRK: state_nx_s = ST_IDLE;
            default:    state_nx_s = ST_IDLE;
         endcase
      end
   end

   // Prefix FSM, held-key vector and the busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         held_r  <= 11'd0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         if (make_s) begin
            held_r <= held_r | mask_s;
         end else if (break_s) begin
            held_r <= held_r & ~mask_s;
         end else begin
            held_r <= held_r;
         end
         busy_r <= (state_nx_s != ST_IDLE) || (count_nx_s != '0);
      end
   end

   // Command FIFO storage, pointers and the registered head presentation.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 4'd0;
         end
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         cmd_valid_r <= 1'b0;
         cmd_code_r  <= 4'd0;
         overflow_r  <= 1'b0;
      end else begin
         if (accept_s) begin
            mem_r[wr_ptr_r] <= key_s;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         rd_ptr_r    <= rd_ptr_nx_s;
         count_r     <= count_nx_s;
         cmd_valid_r <= (count_nx_s != '0);
         cmd_code_r  <= (count_nx_s != '0) ? head_nx_s : 4'd0;
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Quadrant LED with a reloading (never additive) hold counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_r  <= 9'd0;
         hold_r <= '0;
      end else if (quad_pop_s) begin
         led_r  <= quad_onehot(cmd_code_r);
         hold_r <= HOLD_LD;
      end else if (hold_r != '0) begin
         hold_r <= hold_r - HOLD_W'(1);
         if (hold_r == HOLD_W'(1)) begin
            led_r <= 9'd0;
         end
      end
   end

   assign cmd_valid    = cmd_valid_r;
   assign cmd_code     = cmd_code_r;
   assign quadrant_led = led_r;
   assign overflow     = overflow_r;
   assign busy         = busy_r;

endmodule
